axi_txn_ctrl_gen: RTL and testbench
===================================

Name: axi_txn_ctrl_gen

Overview:
Parametrised successor of the X2P AXI-side transaction controller. It buffers AW/AR requests, W data and R data in internal synchronous FIFOs, and exposes the head request fields to the APB master/arbiter. New over the previous generation: configurable data/ID/depth, a B-response FIFO with a full-flag backpressure, per-burst sticky error accumulation with DECERR priority, and a write beat counter. Sits between the AXI slave ports and the APB master FSM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; legal values 32 or 64; strobe width is DATA_W/8
ID_W, 8, AXI ID width
REQ_DEPTH, 4, AW/AR/B FIFO depth; power of 2, at least 2
DATA_DEPTH, 16, W/R FIFO depth; power of 2, at least 4
AFULL_MARGIN, 1, R almost-full when count >= DATA_DEPTH-AFULL_MARGIN
AEMPTY_LEVEL, 2, W almost-empty when count <= AEMPTY_LEVEL

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
awvalid/awready  in/out  1/1  AW handshake
awaddr, awid, awlen, awsize, awburst, awprot  in  ADDR_W, ID_W, 8, 3, 2, 3  AW fields
arvalid/arready  in/out  1/1  AR handshake
araddr, arid, arlen, arsize, arburst, arprot  in  ADDR_W, ID_W, 8, 3, 2, 3  AR fields
wvalid/wready  in/out  1/1  W handshake
wdata, wstrb, wlast  in  DATA_W, DATA_W/8, 1  W fields
rvalid, rdata, rresp, rid, rlast  out  1, DATA_W, 2, ID_W, 1  R channel
rready  in  1  R handshake
bvalid, bresp, bid  out  1, 2, ID_W  B channel
bready  in  1  B handshake
wr_trans_done_i, rd_trans_done_i  in  1  burst-complete pulses from the arbiter
write_to_rd_sfifo_i, read_from_wd_sfifo_i  in  1  APB beat push (R) / pop (W)
prdata_i  in  DATA_W  APB read data
pslverr_i, dec_error_i, latch_resp_i  in  1  APB beat response and write-response strobe
sfifo_aw_empty_o, sfifo_ar_empty_o  out  1  request FIFO empty
sfifo_wd_almost_empty_o, sfifo_rd_almost_full_o  out  1  data FIFO levels
sfifo_b_full_o  out  1  B FIFO full; arbiter must not issue wr_trans_done_i while high
write_burst_{addr,len,size,name,prot}_o  out  ADDR_W, 8, 3, 2, 3  AW head fields
read_burst_{addr,len,size,name,prot}_o  out  ADDR_W, 8, 3, 2, 3  AR head fields
wdata_to_apb_o, wstrb_to_apb_o  out  DATA_W, DATA_W/8  W head

Behaviour:
- Reset (async, areset=1): all FIFO pointers and counters cleared; beat counter = 0; error accumulator = OKAY (2'b00). Valids/almost-full/full outputs = 0; empty flags = 1. ready outputs = 1 after reset release. Head data outputs are don't-care but must be X-free.
- Reset asserted mid-burst discards all buffered content. No response is produced for bursts in flight.
- FIFOs: registered storage; data visible at head the cycle after the write (first-word latency 1). Count-based flags. Push-when-full or pop-when-empty is ignored (pointers hold). Simultaneous push and pop keeps the count unchanged.
- AW/AR: awready = ~aw_full; push on awvalid&awready; pop on wr_trans_done_i. AR mirrors this with rd_trans_done_i.
- W FIFO entry {wdata, wstrb, wlast}: wready = ~wd_full; push on wvalid&wready; pop on read_from_wd_sfifo_i.
- R FIFO entry {last, data, resp, id}: push on write_to_rd_sfifo_i with last = rd_trans_done_i, id = AR head id. Beat resp = ~pslverr_i ? OKAY(00) : dec_error_i ? DECERR(11) : SLVERR(10). rvalid = ~rd_empty; pop on rvalid&rready; rlast = rvalid & head.last.
- Error accumulator: on latch_resp_i with pslverr_i, acc <= max(acc, dec_error_i ? 11 : 10), so DECERR is sticky over SLVERR.
- Beat counter: 9-bit; increments on read_from_wd_sfifo_i; captures the popped wlast.
- On wr_trans_done_i: push {AW head id, final_resp} into the B FIFO. final_resp = max(acc, same-cycle latch contribution, wlast-check contribution). In the same cycle, clear acc and the beat counter. A latch_resp_i in the same cycle as wr_trans_done_i is folded into final_resp, not into the next burst.
- B: bvalid = ~b_empty; bvalid/bid/bresp stay stable until bready; pop on bvalid&bready. sfifo_b_full_o = b_full. A wr_trans_done_i while full is a protocol violation: the push is dropped and the bench asserts an error.
- Back-to-back bursts: wr_trans_done_i on consecutive cycles pushes two distinct B entries, in order.

Optional Feature:
Macro AXI_TXN_CTRL_WLAST_CHECK_EN.
- Defined: at wr_trans_done_i, if beat count != AW head len+1, or the last popped wlast is 0, the wlast-check contribution = SLVERR. Otherwise it is OKAY.
- Undefined: the beat counter and check logic are removed; wlast is stored but ignored for bresp.

Test Plan:
- AW id=0x3A len=3; 4 W beats; 4 pops with pslverr=0; wr_trans_done -> one B beat, bid=0x3A, bresp=00; bvalid held 5 cycles under bready=0.
- Write burst with beat 1 pslverr=1 dec=0 and beat 2 pslverr=1 dec=1 (latched) -> bresp=11; next burst clean -> bresp=00 (accumulator cleared).
- AR id=0x05 len=1; 2 APB pushes, second with rd_trans_done and pslverr=1 dec=0 -> R beats resp 00 then 10, rlast only on the second, rid=0x05; rready=0 holds rdata.
- Fill AW with REQ_DEPTH=4 requests -> awready=0 on the 4th push+1 cycle. Simultaneous pop+push while full keeps awready=0 and count=4. Likewise fill R FIFO to 15 -> almost_full=1.
- With WLAST_CHECK_EN: AW len=3, only 3 beats popped then wr_trans_done -> bresp=10. Without the macro -> bresp=00.
- Assert areset mid-burst with 5 W beats buffered -> next cycle wready=1, bvalid=0, rvalid=0, empty flags=1. A fresh burst then completes correctly.

Source files
------------

// File: rtl/axi_txn_ctrl_gen.sv
// axi_txn_ctrl_gen: AXI-side transaction controller for the AXI-to-APB bridge.
// Buffers AW/AR requests, W data, R data and B responses in small synchronous
// FIFOs and exposes the head request fields to the APB master/arbiter.
// Optional build macro AXI_TXN_CTRL_WLAST_CHECK_EN adds a write beat counter
// that flags SLVERR when a burst ends with the wrong beat count or no wlast.

module axi_txn_ctrl_gen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage and pointers; storage is cleared on reset so head fields are never X.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

module axi_txn_ctrl_gen #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 8,
  parameter int REQ_DEPTH    = 4,
  parameter int DATA_DEPTH   = 16,
  parameter int AFULL_MARGIN = 1,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awprot,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [ID_W-1:0]     arid,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arprot,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic [ID_W-1:0]     rid,
  output logic                rlast,
  input  logic                rready,
  output logic                bvalid,
  output logic [1:0]          bresp,
  output logic [ID_W-1:0]     bid,
  input  logic                bready,
  input  logic                wr_trans_done_i,
  input  logic                rd_trans_done_i,
  input  logic                write_to_rd_sfifo_i,
  input  logic                read_from_wd_sfifo_i,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pslverr_i,
  input  logic                dec_error_i,
  input  logic                latch_resp_i,
  output logic                sfifo_aw_empty_o,
  output logic                sfifo_ar_empty_o,
  output logic                sfifo_wd_almost_empty_o,
  output logic                sfifo_rd_almost_full_o,
  output logic                sfifo_b_full_o,
  output logic [ADDR_W-1:0]   write_burst_addr_o,
  output logic [7:0]          write_burst_len_o,
  output logic [2:0]          write_burst_size_o,
  output logic [1:0]          write_burst_name_o,
  output logic [2:0]          write_burst_prot_o,
  output logic [ADDR_W-1:0]   read_burst_addr_o,
  output logic [7:0]          read_burst_len_o,
  output logic [2:0]          read_burst_size_o,
  output logic [1:0]          read_burst_name_o,
  output logic [2:0]          read_burst_prot_o,
  output logic [DATA_W-1:0]   wdata_to_apb_o,
  output logic [DATA_W/8-1:0] wstrb_to_apb_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = ADDR_W + ID_W + 8 + 3 + 2 + 3;
  localparam int WD_W   = DATA_W + STRB_W + 1;
  localparam int RD_W   = 1 + DATA_W + 2 + ID_W;
  localparam int B_W    = ID_W + 2;
  localparam int RPW    = $clog2(REQ_DEPTH);
  localparam int DPW    = $clog2(DATA_DEPTH);
  localparam logic [DPW:0] RD_AFULL  = (DPW+1)'(DATA_DEPTH - AFULL_MARGIN);
  localparam logic [DPW:0] WD_AEMPTY = (DPW+1)'(AEMPTY_LEVEL);

  logic [REQ_W-1:0] aw_head, ar_head;
  logic [WD_W-1:0]  wd_head;
  logic [RD_W-1:0]  rd_head;
  logic [B_W-1:0]   b_head;
  logic aw_full, aw_empty, ar_full, ar_empty, wd_full, wd_empty;
  logic rd_full, rd_empty, b_full, b_empty;
  logic [RPW:0] aw_count, ar_count, b_count;
  logic [DPW:0] wd_count, rd_count;
  logic [ID_W-1:0] aw_head_id, ar_head_id;
  logic            wd_head_last;
  logic            wd_pop;
  logic [1:0] beat_resp, latch_contrib, wchk_resp, final_resp, err_acc;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  axi_txn_ctrl_gen_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_aw (
    .aclk(aclk), .areset(areset), .push(awvalid & awready),
    .push_data({awaddr, awid, awlen, awsize, awburst, awprot}),
    .pop(wr_trans_done_i), .head(aw_head), .full(aw_full), .empty(aw_empty), .count(aw_count));

  axi_txn_ctrl_gen_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_ar (
    .aclk(aclk), .areset(areset), .push(arvalid & arready),
    .push_data({araddr, arid, arlen, arsize, arburst, arprot}),
    .pop(rd_trans_done_i), .head(ar_head), .full(ar_full), .empty(ar_empty), .count(ar_count));

  axi_txn_ctrl_gen_fifo #(.WIDTH(WD_W), .DEPTH(DATA_DEPTH)) u_wd (
    .aclk(aclk), .areset(areset), .push(wvalid & wready),
    .push_data({wdata, wstrb, wlast}),
    .pop(read_from_wd_sfifo_i), .head(wd_head), .full(wd_full), .empty(wd_empty), .count(wd_count));

  axi_txn_ctrl_gen_fifo #(.WIDTH(RD_W), .DEPTH(DATA_DEPTH)) u_rd (
    .aclk(aclk), .areset(areset), .push(write_to_rd_sfifo_i),
    .push_data({rd_trans_done_i, prdata_i, beat_resp, ar_head_id}),
    .pop(rready), .head(rd_head), .full(rd_full), .empty(rd_empty), .count(rd_count));

  // A completion arriving while the B FIFO is full is dropped outright.
  axi_txn_ctrl_gen_fifo #(.WIDTH(B_W), .DEPTH(REQ_DEPTH)) u_b (
    .aclk(aclk), .areset(areset), .push(wr_trans_done_i & ~b_full),
    .push_data({aw_head_id, final_resp}),
    .pop(bready), .head(b_head), .full(b_full), .empty(b_empty), .count(b_count));

  assign {write_burst_addr_o, aw_head_id, write_burst_len_o, write_burst_size_o,
          write_burst_name_o, write_burst_prot_o} = aw_head;
  assign {read_burst_addr_o, ar_head_id, read_burst_len_o, read_burst_size_o,
          read_burst_name_o, read_burst_prot_o} = ar_head;
  assign {wdata_to_apb_o, wstrb_to_apb_o, wd_head_last} = wd_head;

  assign awready = ~aw_full;
  assign arready = ~ar_full;
  assign wready  = ~wd_full;
  assign rvalid  = ~rd_empty;
  assign rlast   = rvalid & rd_head[RD_W-1];
  assign rdata   = rd_head[RD_W-2 -: DATA_W];
  assign rresp   = rd_head[ID_W +: 2];
  assign rid     = rd_head[ID_W-1:0];
  assign bvalid  = ~b_empty;
  assign {bid, bresp} = b_head;

  assign sfifo_aw_empty_o        = aw_empty;
  assign sfifo_ar_empty_o        = ar_empty;
  assign sfifo_wd_almost_empty_o = (wd_count <= WD_AEMPTY);
  assign sfifo_rd_almost_full_o  = (rd_count >= RD_AFULL);
  assign sfifo_b_full_o          = b_full;

  assign wd_pop        = read_from_wd_sfifo_i & ~wd_empty;
  assign beat_resp     = ~pslverr_i ? 2'b00 : (dec_error_i ? 2'b11 : 2'b10);
  assign latch_contrib = (latch_resp_i & pslverr_i) ? beat_resp : 2'b00;
  assign final_resp    = resp_max(resp_max(err_acc, latch_contrib), wchk_resp);

  // Sticky burst error: numeric max keeps DECERR above SLVERR above OKAY.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)               err_acc <= 2'b00;
    else if (wr_trans_done_i) err_acc <= 2'b00;
    else if (latch_resp_i)    err_acc <= resp_max(err_acc, latch_contrib);
  end

`ifdef AXI_TXN_CTRL_WLAST_CHECK_EN
  logic [8:0] beat_cnt;
  logic       last_wlast;
  logic [8:0] beat_eff;
  logic       wlast_eff;

  // A pop in the completion cycle itself still counts toward this burst.
  assign beat_eff  = beat_cnt + {8'd0, wd_pop};
  assign wlast_eff = wd_pop ? wd_head_last : last_wlast;
  assign wchk_resp = ((beat_eff != ({1'b0, write_burst_len_o} + 9'd1)) || !wlast_eff)
                     ? 2'b10 : 2'b00;

  // Count popped write beats and remember the wlast of the most recent one.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt   <= 9'd0;
      last_wlast <= 1'b0;
    end else if (wr_trans_done_i) begin
      beat_cnt   <= 9'd0;
      last_wlast <= 1'b0;
    end else if (wd_pop) begin
      beat_cnt   <= beat_cnt + 9'd1;
      last_wlast <= wd_head_last;
    end
  end
`else
  assign wchk_resp = 2'b00;
`endif
endmodule

// File: tb/tb_axi_txn_ctrl_gen.sv
// Scoreboard bench for axi_txn_ctrl_gen: directed stimulus pushes expected
// B/R beats into queues, a negedge monitor pops and compares on handshakes.
module tb_axi_txn_ctrl_gen;
  logic aclk = 1'b0, areset = 1'b1;
  logic awvalid = 0, awready; logic [31:0] awaddr = 0; logic [7:0] awid = 0, awlen = 0;
  logic [2:0] awsize = 0, awprot = 0; logic [1:0] awburst = 0;
  logic arvalid = 0, arready; logic [31:0] araddr = 0; logic [7:0] arid = 0, arlen = 0;
  logic [2:0] arsize = 0, arprot = 0; logic [1:0] arburst = 0;
  logic wvalid = 0, wready; logic [31:0] wdata = 0; logic [3:0] wstrb = 0; logic wlast = 0;
  logic rvalid, rlast, rready = 1; logic [31:0] rdata; logic [1:0] rresp; logic [7:0] rid;
  logic bvalid, bready = 1; logic [1:0] bresp; logic [7:0] bid;
  logic wr_trans_done_i = 0, rd_trans_done_i = 0, write_to_rd_sfifo_i = 0, read_from_wd_sfifo_i = 0;
  logic [31:0] prdata_i = 0; logic pslverr_i = 0, dec_error_i = 0, latch_resp_i = 0;
  logic sfifo_aw_empty_o, sfifo_ar_empty_o, sfifo_wd_almost_empty_o, sfifo_rd_almost_full_o, sfifo_b_full_o;
  logic [31:0] write_burst_addr_o, read_burst_addr_o, wdata_to_apb_o;
  logic [7:0] write_burst_len_o, read_burst_len_o;
  logic [2:0] write_burst_size_o, write_burst_prot_o, read_burst_size_o, read_burst_prot_o;
  logic [1:0] write_burst_name_o, read_burst_name_o; logic [3:0] wstrb_to_apb_o;

  int checks = 0, errors = 0;
  typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic [7:0] id; logic last; } r_t;
  b_t b_q[$]; r_t r_q[$]; b_t be; r_t re;
`ifdef AXI_TXN_CTRL_WLAST_CHECK_EN
  localparam logic [1:0] SHORT_RESP = 2'b10;
`else
  localparam logic [1:0] SHORT_RESP = 2'b00;
`endif

  axi_txn_ctrl_gen dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awprot(awprot),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arprot(arprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rready(rready),
    .bvalid(bvalid), .bresp(bresp), .bid(bid), .bready(bready),
    .wr_trans_done_i(wr_trans_done_i), .rd_trans_done_i(rd_trans_done_i),
    .write_to_rd_sfifo_i(write_to_rd_sfifo_i), .read_from_wd_sfifo_i(read_from_wd_sfifo_i),
    .prdata_i(prdata_i), .pslverr_i(pslverr_i), .dec_error_i(dec_error_i), .latch_resp_i(latch_resp_i),
    .sfifo_aw_empty_o(sfifo_aw_empty_o), .sfifo_ar_empty_o(sfifo_ar_empty_o),
    .sfifo_wd_almost_empty_o(sfifo_wd_almost_empty_o), .sfifo_rd_almost_full_o(sfifo_rd_almost_full_o),
    .sfifo_b_full_o(sfifo_b_full_o),
    .write_burst_addr_o(write_burst_addr_o), .write_burst_len_o(write_burst_len_o),
    .write_burst_size_o(write_burst_size_o), .write_burst_name_o(write_burst_name_o),
    .write_burst_prot_o(write_burst_prot_o),
    .read_burst_addr_o(read_burst_addr_o), .read_burst_len_o(read_burst_len_o),
    .read_burst_size_o(read_burst_size_o), .read_burst_name_o(read_burst_name_o),
    .read_burst_prot_o(read_burst_prot_o),
    .wdata_to_apb_o(wdata_to_apb_o), .wstrb_to_apb_o(wstrb_to_apb_o));

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else $display("check %s ok: %0h", name, act);
  endtask

  // Monitor: compare every B/R handshake against the scoreboard queues.
  always @(negedge aclk) begin
    if (bvalid && bready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++; $display("FAIL b_unexpected: got id=%0h resp=%0h, required no beat", bid, bresp);
      end else begin
        be = b_q.pop_front();
        if (bid !== be.id || bresp !== be.resp) begin
          errors++; $display("FAIL b_beat: got id=%0h resp=%0h, required id=%0h resp=%0h", bid, bresp, be.id, be.resp);
        end else $display("B beat id=%0h resp=%0h", bid, bresp);
      end
    end
    if (rvalid && rready) begin
      checks++;
      if (r_q.size() == 0) begin
        errors++; $display("FAIL r_unexpected: got data=%0h, required no beat", rdata);
      end else begin
        re = r_q.pop_front();
        if (rdata !== re.data || rresp !== re.resp || rid !== re.id || rlast !== re.last) begin
          errors++;
          $display("FAIL r_beat: got data=%0h resp=%0h id=%0h last=%0b, required data=%0h resp=%0h id=%0h last=%0b",
                   rdata, rresp, rid, rlast, re.data, re.resp, re.id, re.last);
        end else $display("R beat data=%0h resp=%0h id=%0h last=%0b", rdata, rresp, rid, rlast);
      end
    end
    if (wr_trans_done_i && sfifo_b_full_o) begin
      errors++; $display("FAIL b_protocol: wr_trans_done while B full, required never");
    end
  end

  task automatic tick(); @(posedge aclk); #1; endtask

  task automatic aw_push(input logic [7:0] id, input logic [7:0] len, input logic [31:0] addr);
    awvalid = 1; awid = id; awlen = len; awaddr = addr; awsize = 3'd2; awburst = 2'd1; awprot = 3'd0;
    tick(); awvalid = 0;
  endtask

  task automatic ar_push(input logic [7:0] id, input logic [7:0] len, input logic [31:0] addr);
    arvalid = 1; arid = id; arlen = len; araddr = addr; arsize = 3'd2; arburst = 2'd1; arprot = 3'd1;
    tick(); arvalid = 0;
  endtask

  task automatic w_push(input logic [31:0] d, input logic last);
    wvalid = 1; wdata = d; wstrb = 4'hF; wlast = last; tick(); wvalid = 0; wlast = 0;
  endtask

  task automatic w_pop(input logic perr, input logic dec, input logic latch);
    read_from_wd_sfifo_i = 1; pslverr_i = perr; dec_error_i = dec; latch_resp_i = latch;
    tick(); read_from_wd_sfifo_i = 0; pslverr_i = 0; dec_error_i = 0; latch_resp_i = 0;
  endtask

  task automatic wr_done(input logic [7:0] id, input logic [1:0] exp_resp,
                         input logic perr, input logic dec, input logic latch);
    b_q.push_back('{id: id, resp: exp_resp});
    wr_trans_done_i = 1; pslverr_i = perr; dec_error_i = dec; latch_resp_i = latch;
    tick(); wr_trans_done_i = 0; pslverr_i = 0; dec_error_i = 0; latch_resp_i = 0;
  endtask

  task automatic rd_push(input logic [31:0] d, input logic perr, input logic dec, input logic done,
                         input logic [1:0] exp_resp, input logic [7:0] exp_id);
    r_q.push_back('{data: d, resp: exp_resp, id: exp_id, last: done});
    write_to_rd_sfifo_i = 1; prdata_i = d; pslverr_i = perr; dec_error_i = dec; rd_trans_done_i = done;
    tick(); write_to_rd_sfifo_i = 0; pslverr_i = 0; dec_error_i = 0; rd_trans_done_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 100) begin tick(); n++; end
    chk("drain_pending", 64'(b_q.size() + r_q.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    chk("rst_bvalid", bvalid, 0);         chk("rst_rvalid", rvalid, 0);
    chk("rst_aw_empty", sfifo_aw_empty_o, 1); chk("rst_ar_empty", sfifo_ar_empty_o, 1);
    chk("rst_rd_afull", sfifo_rd_almost_full_o, 0); chk("rst_b_full", sfifo_b_full_o, 0);
    chk("rst_wd_aempty", sfifo_wd_almost_empty_o, 1);
    chk("rst_awready", awready, 1); chk("rst_wready", wready, 1); chk("rst_arready", arready, 1);

    // Clean 4-beat write, B held under bready=0
    aw_push(8'h3A, 8'd3, 32'h100);
    chk("aw_head_len", write_burst_len_o, 3); chk("aw_head_addr", write_burst_addr_o, 32'h100);
    for (int i = 0; i < 4; i++) w_push(32'hD0 + i, i == 3);
    chk("wd_head_data", wdata_to_apb_o, 32'hD0);
    for (int i = 0; i < 4; i++) w_pop(0, 0, 0);
    bready = 0;
    wr_done(8'h3A, 2'b00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_valid", bvalid, 1); chk("b_hold_id", bid, 8'h3A); tick();
    end
    bready = 1; drain();

    // Sticky DECERR, then cleared accumulator, then same-cycle latch fold
    aw_push(8'h11, 8'd3, 32'h200);
    for (int i = 0; i < 4; i++) w_push(32'hE0 + i, i == 3);
    w_pop(0, 0, 0); w_pop(1, 0, 1); w_pop(1, 1, 1); w_pop(0, 0, 0);
    wr_done(8'h11, 2'b11, 0, 0, 0);
    aw_push(8'h12, 8'd0, 32'h300); w_push(32'hF0, 1); w_pop(0, 0, 0);
    wr_done(8'h12, 2'b00, 0, 0, 0);
    aw_push(8'h13, 8'd0, 32'h304); w_push(32'hF1, 1); w_pop(0, 0, 0);
    wr_done(8'h13, 2'b10, 1, 0, 1);
    aw_push(8'h14, 8'd0, 32'h308); w_push(32'hF2, 1); w_pop(0, 0, 0);
    wr_done(8'h14, 2'b00, 0, 0, 0);
    drain();

    // Two-beat read, second with SLVERR; rready=0 holds data
    rready = 0;
    ar_push(8'h05, 8'd1, 32'h400);
    chk("ar_head_len", read_burst_len_o, 1);
    rd_push(32'hA1, 0, 0, 0, 2'b00, 8'h05);
    rd_push(32'hB2, 1, 0, 1, 2'b10, 8'h05);
    chk("ar_empty_after_done", sfifo_ar_empty_o, 1);
    for (int i = 0; i < 3; i++) begin
      chk("r_hold_valid", rvalid, 1); chk("r_hold_data", rdata, 32'hA1); chk("r_hold_last", rlast, 0); tick();
    end
    rready = 1; drain();

    // Fill AW FIFO to depth 4, then retire bursts one by one
    for (int i = 0; i < 4; i++) aw_push(8'h20 + 8'(i), 8'd0, 32'h1000 + 32'(i * 4));
    chk("aw_full_ready", awready, 0); chk("aw_full_head", write_burst_addr_o, 32'h1000);
    for (int i = 0; i < 4; i++) begin
      w_push(32'h50 + 32'(i), 1); w_pop(0, 0, 0);
      wr_done(8'h20 + 8'(i), 2'b00, 0, 0, 0);
      chk("aw_ready_after_pop", awready, 1);
      if (i < 3) chk("aw_next_head", write_burst_addr_o, 32'h1000 + 32'((i + 1) * 4));
    end
    chk("aw_empty_end", sfifo_aw_empty_o, 1);
    drain();

    // Fill R FIFO; almost-full at 15; push+pop while full keeps it full
    rready = 0;
    ar_push(8'h07, 8'd16, 32'h500);
    for (int i = 0; i < 16; i++) begin
      rd_push(32'h100 + 32'(i), 0, 0, 0, 2'b00, 8'h07);
      if (i == 13) chk("rd_afull_14", sfifo_rd_almost_full_o, 0);
      if (i == 14) chk("rd_afull_15", sfifo_rd_almost_full_o, 1);
    end
    rready = 1;
    rd_push(32'h200, 0, 0, 1, 2'b00, 8'h07);
    rready = 0;
    chk("rd_afull_pushpop", sfifo_rd_almost_full_o, 1);
    chk("rd_head_advanced", rdata, 32'h101);
    rready = 1; drain();
    chk("rd_drained_valid", rvalid, 0);

    // Short burst: 3 of 4 beats popped
    aw_push(8'h30, 8'd3, 32'h600);
    for (int i = 0; i < 4; i++) w_push(32'h70 + 32'(i), i == 3);
    for (int i = 0; i < 3; i++) w_pop(0, 0, 0);
    wr_done(8'h30, SHORT_RESP, 0, 0, 0);
    drain();

    // Reset mid-burst with buffered W beats, then a fresh burst
    for (int i = 0; i < 5; i++) w_push(32'h80 + 32'(i), i == 4);
    chk("wd_not_aempty", sfifo_wd_almost_empty_o, 0);
    aw_push(8'h31, 8'd4, 32'h700); ar_push(8'h32, 8'd0, 32'h800);
    #3 areset = 1;
    #1;
    chk("mid_rst_wready", wready, 1); chk("mid_rst_bvalid", bvalid, 0); chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_aw_empty", sfifo_aw_empty_o, 1); chk("mid_rst_ar_empty", sfifo_ar_empty_o, 1);
    chk("mid_rst_wd_aempty", sfifo_wd_almost_empty_o, 1);
    tick(); areset = 0;
    aw_push(8'h3C, 8'd1, 32'h900);
    w_push(32'hC0, 0); w_push(32'hC1, 1);
    chk("post_rst_wd_head", wdata_to_apb_o, 32'hC0);
    w_pop(0, 0, 0); w_pop(0, 0, 0);
    wr_done(8'h3C, 2'b00, 0, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
